// File: rtl/uart_rx_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_rx_pkg: shared states, prescale constants and parity encodings  |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  localparam int unsigned PRESCALE_8       = 8;
  localparam int unsigned PRESCALE_16      = 16;
  localparam int unsigned PRESCALE_32      = 32;
  localparam int unsigned PRESCALE_DEFAULT = PRESCALE_8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic int unsigned legal_prescale(input int unsigned p);
    if (p == PRESCALE_8 || p == PRESCALE_16 || p == PRESCALE_32) begin
      return p;
    end
    return PRESCALE_DEFAULT;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_bit_sampler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_rx_bit_sampler: per-bit tick counter and 3-point majority vote  |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module uart_rx_bit_sampler #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  sampled_bit,
  output logic                  bit_end
);

  logic [PRESCALE_W-1:0] r_edge_cnt;
  logic [1:0]            r_early;
  logic                  r_sampled;

  logic [PRESCALE_W-1:0] w_half;
  logic [PRESCALE_W-1:0] w_last;
  logic                  w_majority;

  assign w_half     = prescale >> 1;
  assign w_last     = prescale - PRESCALE_W'(1);
  assign w_majority = (r_early[0] & r_early[1]) | (r_early[0] & rx_in) | (r_early[1] & rx_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_edge_cnt <= '0;
      r_early    <= '0;
      r_sampled  <= 1'b0;
    end else if (clear) begin
      r_edge_cnt <= '0;
    end else begin
      r_edge_cnt <= (r_edge_cnt == w_last) ? '0 : r_edge_cnt + PRESCALE_W'(1);
      if (r_edge_cnt == w_half - PRESCALE_W'(2)) r_early[0] <= rx_in;
      if (r_edge_cnt == w_half - PRESCALE_W'(1)) r_early[1] <= rx_in;
      // Third sample is taken live so the vote is registered by P/2+1
      if (r_edge_cnt == w_half) r_sampled <= w_majority;
    end
  end

  assign sampled_bit = r_sampled;
  assign bit_end     = !clear && (r_edge_cnt == w_last);

endmodule
`default_nettype wire

// File: rtl/uart_rx_frame_core.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_rx_frame_core: UART frame FSM, deserialiser and error checks    |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module uart_rx_frame_core
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);

  localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_CNT_W-1:0] c_last_bit = BIT_CNT_W'(DATA_WIDTH - 1);

  rx_state_t r_state, w_next;

  logic [PRESCALE_W-1:0] r_prescale;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_frame_bad;
  logic [DATA_WIDTH-1:0] r_p_data;
  logic                  r_data_valid;
  logic                  r_par_err;
  logic                  r_stp_err;

  logic                  w_idle;
  logic                  w_start_det;
  logic                  w_sampled;
  logic                  w_bit_end;
  logic                  w_par_expected;
  logic [PRESCALE_W-1:0] w_prescale_legal;

  assign w_idle           = (r_state == ST_IDLE);
  assign w_start_det      = w_idle && !RX_IN;
  assign w_prescale_legal = PRESCALE_W'(legal_prescale(32'(PRESCALE)));
  assign w_par_expected   = (^r_shift) ^ (r_par_typ == PAR_ODD);

  uart_rx_bit_sampler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_sampler (
    .clk         (CLK),
    .rst         (RST),
    .clear       (w_idle),
    .rx_in       (RX_IN),
    .prescale    (r_prescale),
    .sampled_bit (w_sampled),
    .bit_end     (w_bit_end)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (!RX_IN) w_next = ST_START;
      ST_START:  if (w_bit_end) w_next = w_sampled ? ST_IDLE : ST_DATA;
      ST_DATA:   if (w_bit_end && r_bit_cnt == c_last_bit) w_next = r_par_en ? ST_PARITY : ST_STOP;
      ST_PARITY: if (w_bit_end) w_next = ST_STOP;
      ST_STOP:   if (w_bit_end) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_prescale   <= PRESCALE_W'(PRESCALE_DEFAULT);
      r_par_en     <= 1'b0;
      r_par_typ    <= PAR_EVEN;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_frame_bad  <= 1'b0;
      r_p_data     <= '0;
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
      // Configuration is frozen for the whole frame
      if (w_start_det) begin
        r_prescale  <= w_prescale_legal;
        r_par_en    <= PAR_EN;
        r_par_typ   <= PAR_TYP;
        r_frame_bad <= 1'b0;
      end
      if (w_bit_end) begin
        case (r_state)
          ST_START: r_bit_cnt <= '0;
          ST_DATA: begin
            r_shift   <= {w_sampled, r_shift[DATA_WIDTH-1:1]};
            r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
          end
          ST_PARITY: begin
            if (w_sampled != w_par_expected) begin
              r_par_err   <= 1'b1;
              r_frame_bad <= 1'b1;
            end
          end
          ST_STOP: begin
            if (!w_sampled) begin
              r_stp_err <= 1'b1;
            end else if (!r_frame_bad) begin
              r_p_data     <= r_shift;
              r_data_valid <= 1'b1;
            end
            r_frame_bad <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign P_DATA     = r_p_data;
  assign DATA_VALID = r_data_valid;
  assign PAR_ERR    = r_par_err;
  assign STP_ERR    = r_stp_err;

endmodule
`default_nettype wire

// File: doc/uart_rx_frame_core.md
Name: uart_rx_frame_core

Overview:
- Serial UART receive core clocked by the oversampling clock from the Rx clock divider (O_DIV_CLK feeds CLK).
- One CLK cycle = one oversample tick; PRESCALE ticks = one bit period.
- Detects the start bit, majority-samples each bit, deserialises LSB-first, and checks optional parity and the stop bit.
- Delivers the received byte to the Rx data synchroniser downstream as a one-cycle DATA_VALID pulse.

Parameters:
- DATA_WIDTH, 8, payload bits per frame.
- PRESCALE_W, 6, width of the PRESCALE input; legal PRESCALE values are 8, 16 and 32.

Ports:
- CLK  input  1  oversample clock (divided clock); all logic on posedge.
- RST  input  1  asynchronous, active-high reset.
- RX_IN  input  1  serial line, already synchronised; idle high.
- PRESCALE  input  PRESCALE_W  oversample ticks per bit.
- PAR_EN  input  1  1 = parity bit present between the data bits and the stop bit.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- P_DATA  output  DATA_WIDTH  last good byte; held until the next good frame.
- DATA_VALID  output  1  one-cycle pulse when P_DATA is updated.
- PAR_ERR  output  1  one-cycle pulse on a parity mismatch.
- STP_ERR  output  1  one-cycle pulse when the stop bit samples 0.

Behaviour:
- Reset (asynchronous, active-high):
  - State = IDLE; all counters = 0.
  - P_DATA = 0; DATA_VALID, PAR_ERR and STP_ERR = 0.
  - Asserting RST mid-frame aborts the frame with no pulse on any output.
- Configuration latch:
  - PRESCALE, PAR_EN and PAR_TYP are latched on IDLE->START.
  - Changes to these inputs mid-frame are ignored.
  - An illegal latched PRESCALE is treated as 8.
- Counters:
  - edge_cnt counts 0..P-1 within a bit; P is the latched prescale.
  - bit_cnt counts 0..DATA_WIDTH-1 in the DATA state.
- Sampling:
  - RX_IN is sampled at edge_cnt = P/2-2, P/2-1 and P/2.
  - The sampled bit is the majority (2 of 3) vote, registered by edge_cnt = P/2+1.
  - All bit decisions are taken at edge_cnt = P-1, the last tick of the bit.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: RX_IN = 0 -> START with edge_cnt = 0. Otherwise remain in IDLE.
  - START, at P-1: sampled bit 0 -> DATA with bit_cnt = 0. Sampled bit 1 is a glitch -> IDLE, no error pulse.
  - DATA, at each P-1: shift the sampled bit into the shift register at the MSB, shifting right, so the first bit received ends in bit 0. bit_cnt = DATA_WIDTH-1 -> PARITY if PAR_EN = 1, else STOP.
  - PARITY, at P-1: expected bit = XOR of the shift register, inverted when PAR_TYP = 1. Mismatch -> PAR_ERR = 1 for the next cycle and an internal frame-bad flag is set. Always -> STOP.
  - STOP, at P-1: sampled bit 0 -> STP_ERR pulse. Stop bit good and frame-bad flag clear -> P_DATA <= shift register and DATA_VALID pulse. Always -> IDLE; the frame-bad flag clears.
- Latency: DATA_VALID rises on the cycle after edge_cnt = P-1 of the stop bit.
  - That is (10+PAR_EN)*P cycles after START entry.
- Back-to-back frames: the IDLE detection rule applies on the cycle after STOP.
  - Detection of a start bit that begins immediately after the stop bit is therefore one tick late; this is within tolerance by design.
- Simultaneous errors: PAR_ERR and STP_ERR pulse on different cycles (PARITY end, STOP end).
  - Any error suppresses DATA_VALID for that frame.
  - P_DATA keeps its previous value when a frame is bad.
- Never hangs: every non-IDLE state exits after exactly P ticks.

Decomposition:
- Package uart_rx_pkg holds:
  - the state enum;
  - the legal-prescale constants 8, 16, 32 and the default of 8;
  - the PAR_TYP encodings EVEN = 0 and ODD = 1.
- Sub-module uart_rx_bit_sampler holds edge_cnt, the three-point sampler and the majority voter.
  - Outputs: sampled_bit, bit_end (edge_cnt = P-1).
  - It is cleared on frame start.
- The top level holds the FSM, bit_cnt, the shift register, the parity check and the output registers.

Test Plan:
- P=8, PAR_EN=0, frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> P_DATA = 0xA5; DATA_VALID high for exactly one cycle, 80 cycles after START entry; no error pulses.
- P=16, PAR_EN=1, PAR_TYP=0, byte 0x3C with parity bit 0 -> DATA_VALID, P_DATA = 0x3C. Repeat with parity bit 1 -> PAR_ERR pulse only, P_DATA stays 0x3C, no DATA_VALID.
- P=8, byte 0x55 with stop bit driven 0 -> STP_ERR pulse at the end of the stop bit; no DATA_VALID; the FSM returns to IDLE.
- P=32, RX_IN low for 4 ticks then high (glitch) -> START aborts at tick 31; no output pulses; the next valid frame 0x81 is received correctly.
- Each data bit's P/2-1 sample flipped (single glitch), P=16, 0xF0 -> majority vote recovers P_DATA = 0xF0.
- RST asserted at bit 4 of a frame, then released -> all outputs 0; the following frame 0x12 is received correctly; PRESCALE changed mid-frame from 8 to 16 has no effect on the current frame.
